// File: rtl/bus_write_queue.sv
// Host-bus write front end: synchronizes the 6502-style bus, queues completed
// writes as {rs,data}, and drains them into the register file / screen-RAM port.
module bus_write_queue #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_ext1,
  input  logic                     cs,
  input  logic                     wren,
  input  logic [3:0]               rs,
  input  logic [7:0]               data_in,
  output logic [7:0]               mode_o,
  output logic [7:0]               ctrl_o,
  output logic [15:0]              scr_wr_addr,
  output logic [7:0]               scr_wr_data,
  output logic                     scr_wr_en,
  input  logic                     scr_wr_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, EXEC} state_t;

  logic [SYNC_STAGES-1:0] ext_sync, cs_sync, wren_sync;
  logic                   ext_s, cs_s, wren_s, ext_prev;
  logic                   pending;
  logic [3:0]             hold_rs;
  logic [7:0]             hold_data;
  logic                   push, pop, push_ok;

  logic [11:0]            mem [DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [11:0]            head;

  state_t                 state;
  logic [3:0]             entry_rs;
  logic [7:0]             entry_data;
  logic [7:0]             regs [16];

  // Synchronizers come out of reset at bus-idle levels so no phantom write is seen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_sync  <= '0;
      cs_sync   <= '1;
      wren_sync <= '1;
    end else begin
      ext_sync  <= {ext_sync[SYNC_STAGES-2:0], clk_ext1};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      wren_sync <= {wren_sync[SYNC_STAGES-2:0], wren};
    end
  end

  assign ext_s  = ext_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign wren_s = wren_sync[SYNC_STAGES-1];

  assign push    = ext_prev & ~ext_s & pending;
  assign pop     = (state == IDLE) && (fifo_level != '0);
  assign push_ok = push && ((fifo_level < DEPTH_L) || pop);
  assign head    = mem[rd_ptr];

  // Data is re-latched every cycle of phase 2 so the last value before the falling edge wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_prev  <= 1'b0;
      pending   <= 1'b0;
      hold_rs   <= '0;
      hold_data <= '0;
    end else begin
      ext_prev <= ext_s;
      if (ext_s && !cs_s && !wren_s) begin
        hold_rs   <= rs;
        hold_data <= data_in;
        pending   <= 1'b1;
      end else if (push) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= {hold_rs, hold_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)
        fifo_level <= fifo_level + 1'b1;
      else if (!push_ok && pop)
        fifo_level <= fifo_level - 1'b1;
      if (push && !push_ok)
        overflow <= 1'b1;
    end
  end

  // Screen writes raise the request on the pop edge so the RAM port sees it one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      entry_rs    <= '0;
      entry_data  <= '0;
      scr_wr_en   <= 1'b0;
      scr_wr_data <= '0;
      for (int i = 0; i < 16; i++)
        regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            entry_rs   <= head[11:8];
            entry_data <= head[7:0];
            state      <= EXEC;
            if (head[11:8] == 4'd1) begin
              regs[1]     <= head[7:0];
              scr_wr_en   <= 1'b1;
              scr_wr_data <= head[7:0];
            end
          end
        end
        EXEC: begin
          if (entry_rs == 4'd1) begin
            if (scr_wr_ready) begin
              scr_wr_en <= 1'b0;
              if (regs[2][0])
                {regs[4], regs[3]} <= {regs[4], regs[3]} + 16'd1;
              state <= IDLE;
            end
          end else begin
            regs[entry_rs] <= entry_data;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mode_o      = regs[0];
  assign ctrl_o      = regs[2];
  assign scr_wr_addr = {regs[4], regs[3]};

endmodule
